// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared encodings for the ID->EX stage
package id_ex_pkg;
    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_NONE  = 2'b11
    } ext_op_e;
    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RA   = 2'b01,
        DST_RD   = 2'b10,
        DST_NONE = 2'b11
    } dst_sel_e;
    localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/id_ex_imm_gen.sv
// id_ex_imm_gen: combinational immediate extension and writeback address select
module id_ex_imm_gen
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic [20:0]       ir,
    input  ext_op_e           ext_op,
    input  dst_sel_e          dst_sel,
    output logic [DATA_W-1:0] imm,
    output logic [RA_W-1:0]   wa
);
    logic [31:0]       upper;
    logic [DATA_W-1:0] sext;
    // pick the immediate form and the destination register field
    always_comb begin
        upper = {ir[15:0], 16'h0};
        sext  = ({DATA_W{ir[15]}} << 16) | DATA_W'(ir[15:0]);
        imm   = ext_op == EXT_SIGN  ? sext :
                ext_op == EXT_ZERO  ? DATA_W'(ir[15:0]) :
                ext_op == EXT_UPPER ? DATA_W'(upper) : '0;
        wa    = dst_sel == DST_RT ? RA_W'(ir[20:16]) :
                dst_sel == DST_RA ? '1 :
                dst_sel == DST_RD ? RA_W'(ir[15:11]) : '0;
    end
endmodule

// File: rtl/id_ex_skid.sv
// id_ex_skid: ID->EX stage with a two-entry skid buffer; ID_EX_PERF_EN adds stall/bubble counters
module id_ex_skid
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [1:0]        in_ext_op,
    input  logic [1:0]        in_dst_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [RA_W-1:0]   out_wa,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef struct packed {
        logic [31:0]       ir;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [RA_W-1:0]   wa;
    } entry_t;

    entry_t            main_q, skid_q, cap;
    logic              main_v, skid_v, in_fire;
    logic [DATA_W-1:0] cap_imm;
    logic [RA_W-1:0]   cap_wa;

    id_ex_imm_gen #(.DATA_W(DATA_W), .RA_W(RA_W)) u_imm (
        .ir      (in_ir[20:0]),
        .ext_op  (ext_op_e'(in_ext_op)),
        .dst_sel (dst_sel_e'(in_dst_sel)),
        .imm     (cap_imm),
        .wa      (cap_wa)
    );

    assign in_ready = ~skid_v;
    assign in_fire  = in_valid & ~skid_v;
    assign cap      = '{ir: in_ir, pc: in_pc, rd1: in_rd1, rd2: in_rd2, imm: cap_imm, wa: cap_wa};

    // main/skid occupancy; an emptied entry is zeroed so outputs read as a nop
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (skid_v) begin
            if (out_ready) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
                skid_q <= '0;
            end
        end else if (main_v) begin
            if (out_ready) begin
                main_v <= in_fire;
                main_q <= in_fire ? cap : '0;
            end else if (in_fire) begin
                skid_v <= 1'b1;
                skid_q <= cap;
            end
        end else if (in_fire) begin
            main_v <= 1'b1;
            main_q <= cap;
        end

    assign out_valid = main_v;
    assign out_ir    = main_v ? main_q.ir : NOP;
    assign out_pc    = main_q.pc;
    assign out_rd1   = main_q.rd1;
    assign out_rd2   = main_q.rd2;
    assign out_imm   = main_q.imm;
    assign out_wa    = main_q.wa;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q;
    // saturating stall and bubble counters, cleared only by reset
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_v & ~out_ready & ~&stall_q) stall_q <= stall_q + CNT_W'(1);
            if (~main_v & ~&bubble_q) bubble_q <= bubble_q + CNT_W'(1);
        end
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_id_ex_skid.sv
// tb_id_ex_skid: directed checks of the ID->EX skid stage
module tb_id_ex_skid;
    logic        clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [31:0] in_ir = 0, in_pc = 0, in_rd1 = 0, in_rd2 = 0;
    logic [1:0]  in_ext_op = 0, in_dst_sel = 0;
    logic [31:0] out_ir, out_pc, out_rd1, out_rd2, out_imm;
    logic [4:0]  out_wa;
    logic [31:0] stall_cnt, bubble_cnt;
    int passed = 0, total = 0, fails = 0;

    always #5 clk = ~clk;

    id_ex_skid dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2),
        .in_ext_op(in_ext_op), .in_dst_sel(in_dst_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_pc(out_pc), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_imm(out_imm), .out_wa(out_wa), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

`ifdef ID_EX_PERF_EN
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_ir, s_pc, s_rd1, s_rd2, s_imm;
    logic [4:0]  s_wa;
    logic [3:0]  s_stall, s_bubble;
    id_ex_skid #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(1'b0), .in_ready(s_in_ready),
        .in_ir(32'h0), .in_pc(32'h0), .in_rd1(32'h0), .in_rd2(32'h0),
        .in_ext_op(2'b00), .in_dst_sel(2'b00), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_ir(s_ir), .out_pc(s_pc), .out_rd1(s_rd1), .out_rd2(s_rd2),
        .out_imm(s_imm), .out_wa(s_wa), .stall_cnt(s_stall), .bubble_cnt(s_bubble)
    );
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [1:0] e, input logic [1:0] d);
        in_valid   = v;
        in_ir      = ir;
        in_pc      = ir ^ 32'h0000_1000;
        in_rd1     = ~ir;
        in_rd2     = ir + 32'd7;
        in_ext_op  = e;
        in_dst_sel = d;
    endtask

    initial begin
        step;
        step;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ir", out_ir, 0);
        chk("rst_out_wa", out_wa, 0);
        reset = 1;
        out_ready = 1;
        drive(1, 32'h3422_8001, 2'b01, 2'b00);
        step;
        chk("ori_valid", out_valid, 1);
        chk("ori_ir", out_ir, 32'h3422_8001);
        chk("ori_pc", out_pc, 32'h3422_9001);
        chk("ori_rd1", out_rd1, 32'hCBDD_7FFE);
        chk("ori_imm", out_imm, 32'h0000_8001);
        chk("ori_wa", out_wa, 2);
        drive(1, 32'h8C41_FFFC, 2'b00, 2'b00);
        step;
        chk("lw_imm", out_imm, 32'hFFFF_FFFC);
        chk("lw_wa", out_wa, 1);
        drive(1, 32'h3C01_1234, 2'b10, 2'b00);
        step;
        chk("lui_imm", out_imm, 32'h1234_0000);
        drive(1, 32'h0C00_0010, 2'b11, 2'b01);
        step;
        chk("jal_imm", out_imm, 0);
        chk("jal_wa", out_wa, 31);
        drive(1, 32'h0022_1820, 2'b11, 2'b10);
        step;
        chk("add_wa", out_wa, 3);
        drive(1, 32'h0022_1820, 2'b01, 2'b11);
        step;
        chk("none_wa", out_wa, 0);
        chk("zero_imm", out_imm, 32'h0000_1820);
        drive(0, 32'h0, 2'b00, 2'b00);
        step;
        chk("empty_valid", out_valid, 0);
        chk("empty_ir", out_ir, 0);
        chk("empty_imm", out_imm, 0);
        // stall: A, B, C with out_ready low
        out_ready = 0;
        drive(1, 32'hAAAA_0001, 2'b00, 2'b00);
        step;
        chk("stall_a_ir", out_ir, 32'hAAAA_0001);
        chk("stall_a_ready", in_ready, 1);
        drive(1, 32'hBBBB_0002, 2'b00, 2'b00);
        step;
        chk("stall_skid_ready", in_ready, 0);
        chk("stall_hold_a", out_ir, 32'hAAAA_0001);
        drive(1, 32'hCCCC_0003, 2'b00, 2'b00);
        step;
        chk("stall_still_a", out_ir, 32'hAAAA_0001);
        chk("stall_still_full", in_ready, 0);
        out_ready = 1;
        step;
        chk("drain_b", out_ir, 32'hBBBB_0002);
        chk("drain_ready", in_ready, 1);
        step;
        chk("drain_c", out_ir, 32'hCCCC_0003);
        drive(0, 32'h0, 2'b00, 2'b00);
        step;
        chk("drain_empty", out_valid, 0);
        // flush with both entries held
        out_ready = 0;
        drive(1, 32'h1111_0001, 2'b01, 2'b00);
        step;
        drive(1, 32'h2222_0002, 2'b01, 2'b00);
        step;
        chk("pre_flush_full", in_ready, 0);
        drive(1, 32'h3333_0003, 2'b01, 2'b00);
        flush = 1;
        step;
        chk("flush_valid", out_valid, 0);
        chk("flush_ir", out_ir, 0);
        chk("flush_imm", out_imm, 0);
        chk("flush_wa", out_wa, 0);
        chk("flush_ready", in_ready, 1);
        step;
        chk("flush_fire_dropped", out_valid, 0);
        flush = 0;
        drive(0, 32'h0, 2'b00, 2'b00);
        step;
        chk("flush_input_absent", out_valid, 0);
        // async reset mid-stall
        drive(1, 32'h4444_0004, 2'b00, 2'b00);
        step;
        drive(1, 32'h5555_0005, 2'b00, 2'b00);
        step;
        chk("prereset_full", in_ready, 0);
        #2 reset = 0;
        #1;
        chk("areset_valid", out_valid, 0);
        chk("areset_ready", in_ready, 1);
        chk("areset_ir", out_ir, 0);
        chk("areset_pc", out_pc, 0);
        // perf: 1 bubble, 3 stalls, 1 drain, 2 bubbles
        step;
        reset = 1;
        out_ready = 0;
        drive(1, 32'h6666_0006, 2'b00, 2'b00);
        step;
        drive(0, 32'h0, 2'b00, 2'b00);
        step;
        step;
        step;
        out_ready = 1;
        step;
        step;
        step;
`ifdef ID_EX_PERF_EN
        chk("stall_cnt", stall_cnt, 3);
        chk("bubble_cnt", bubble_cnt, 3);
        repeat (20) step;
        chk("sat_bubble", s_bubble, 4'hF);
        chk("sat_stall", s_stall, 0);
        chk("main_bubble_keeps_counting", bubble_cnt, 23);
`else
        chk("stall_cnt_tied", stall_cnt, 0);
        chk("bubble_cnt_tied", bubble_cnt, 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/id_ex_skid.md
# id_ex_skid

Parametrised ID→EX pipeline stage with a valid/ready handshake and a two-entry skid buffer, so stalls do not need a combinational ready path back into decode. Generates the extended immediate and the writeback register address from decode-supplied select codes. Flush squashes all held instructions. Sits between the register-file read in ID and the ALU/bypass muxes in EX.

## Interface
- `DATA_W`, 32: datapath width for PC, operands and immediate; must be ≥ 16.
- `RA_W`, 5: register address width.
- `CNT_W`, 32: performance counter width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of every held entry.
- `in_valid` in 1: ID presents an instruction.
- `in_ready` out 1: stage can accept; registered, equals NOT skid-full.
- `in_ir` in 32: instruction word.
- `in_pc` in DATA_W: instruction PC.
- `in_rd1`, `in_rd2` in DATA_W: register operands.
- `in_ext_op` in 2: immediate mode. 00 sign, 01 zero, 10 upper, 11 none.
- `in_dst_sel` in 2: destination select. 00 rt, 01 ra, 10 rd, 11 none.
- `out_valid` out 1: EX entry valid.
- `out_ready` in 1: EX accepts.
- `out_ir` out 32, `out_pc`, `out_rd1`, `out_rd2`, `out_imm` out DATA_W, `out_wa` out RA_W: EX payload.
- `stall_cnt`, `bubble_cnt` out CNT_W: performance counters; see Configuration.

## Operation
- Fires: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: a main entry drives the outputs; a skid entry holds overflow.
- The stage computes imm and wa at capture time and stores them, not the select codes.
- Empty main, in_fire: the input loads main.
- Full main, no skid, out_fire and in_fire: the input replaces main.
- Full main, no skid, no out_fire, in_fire: the input loads skid, so `in_ready` drops next cycle.
- Full main, skid valid, out_fire: skid moves to main. No in_fire is possible because `in_ready` is 0.
- Full main, out_fire, no in_fire, no skid: main becomes empty.
- `flush` has top priority. Both valid bits and all payloads clear to 0 next cycle, and an in_fire in the same cycle is discarded.
- While `out_valid` = 0, every payload output reads 0 (nop, wa 0).
- Immediate from `ir[15:0]`:
  - sign: sign-extended to DATA_W.
  - zero: zero-extended.
  - upper: `ir[15:0]` shifted left 16, zero-filled, truncated/extended to DATA_W.
  - none: 0.
- Write address:
  - rt = `ir[20:16]`.
  - ra = all-ones of RA_W (31 for RA_W = 5).
  - rd = `ir[15:11]`.
  - none = 0.
- For RA_W > 5, rt and rd are zero-extended.

## Timing
- Reset: `out_valid` 0, skid empty, `in_ready` 1, all payloads 0, counters 0. Reset is asynchronous assert and synchronous deassert, supplied externally.
- Latency: one cycle from in_fire into an empty stage to `out_valid`.
- Throughput: one instruction per cycle while `out_ready` = 1.
- `in_ready` has no combinational path from `out_ready`.
- EX may drop `out_ready` for any number of cycles with no instruction lost or duplicated, and order is preserved.
- Reset mid-stall discards both entries immediately.

## Configuration
- `ID_EX_PERF_EN` defined:
  - `stall_cnt` increments each cycle with `out_valid & ~out_ready`.
  - `bubble_cnt` increments each cycle with `~out_valid`.
  - Both saturate at all-ones.
  - Both are cleared only by reset; flush does not clear them.
- `ID_EX_PERF_EN` undefined: no counter registers exist, and both ports are tied to 0.

## Structure
- Package `id_ex_pkg` holds:
  - ext_op encodings: EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_NONE.
  - dst_sel encodings: DST_RT, DST_RA, DST_RD, DST_NONE.
  - The NOP word constant (0).
- Sub-module `id_ex_imm_gen` is combinational. It takes ir, ext_op and dst_sel and produces imm and wa.
- Handshake and storage stay in the top module.

## Test plan
- Basic flow: reset, then ori `ir=0x3422_8001` with ext zero and dst rt, `out_ready`=1. One cycle later: `out_valid`=1, `out_imm`=0x0000_8001, `out_wa`=2.
- Sign and upper: lw with imm 0xFFFC and ext sign gives 0xFFFF_FFFC. lui with imm 0x1234 and ext upper gives 0x1234_0000. jal with dst ra gives wa 31.
- Stall/skid: stream A, B, C with `out_ready` low from the cycle A appears.
  - B lands in skid, and `in_ready`=0 the next cycle.
  - Raise `out_ready`: A, B, C emerge in order, no loss or duplication.
- Flush while main and skid are both valid and in_fire is active: next cycle `out_valid`=0, all outputs 0, `in_ready`=1, the flushed-cycle input is absent.
- Async reset asserted mid-clock during a stall: outputs reach reset values without a clock edge.
- With `ID_EX_PERF_EN`: 3 stall cycles then 2 empty cycles give `stall_cnt`=3 and `bubble_cnt`≥2. Saturation is checked with CNT_W=4.
